// File: rtl/rv32i_control_fsm_if.sv
// rv32i_control_fsm_if: sequencer bus bundle for the minimal RV32I core.
// master = control FSM, slave = datapath/memory side.
interface rv32i_control_fsm_if #(
   parameter int CNT_W = 32
);
   logic             imem_req;
   logic             imem_ack;
   logic             ir_we;
   logic [9:0]       op_class;
   logic             branch_taken;
   logic             dmem_req;
   logic             dmem_we;
   logic             dmem_ack;
   logic             pc_we;
   logic [1:0]       pc_sel;
   logic             alu_a_sel;
   logic             alu_b_sel;
   logic             rf_we;
   logic [1:0]       wb_sel;
   logic             trap;
   logic [1:0]       trap_cause;
   logic [CNT_W-1:0] instret;
   logic [2:0]       state;
   modport master (
      input  imem_ack, op_class, branch_taken, dmem_ack,
      output imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, alu_a_sel, alu_b_sel,
             rf_we, wb_sel, trap, trap_cause, instret, state
   );
   modport slave (
      output imem_ack, op_class, branch_taken, dmem_ack,
      input  imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, alu_a_sel, alu_b_sel,
             rf_we, wb_sel, trap, trap_cause, instret, state
   );
endinterface

// File: rtl/rv32i_control_fsm.sv
// rv32i_control_fsm: multi-cycle fetch/decode/execute/mem/writeback sequencer
// with retired-instruction counter and sticky trap on illegal opcode or bus timeout.
module rv32i_control_fsm #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input logic                 clk,
   input logic                 rst,
   rv32i_control_fsm_if.master bus
);
   localparam int TW = $clog2(TIMEOUT);
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;
   state_t           r_state, w_next;
   logic [9:0]       r_cls;
   logic [TW-1:0]    r_tmo;
   logic [CNT_W-1:0] r_instret;
   logic [1:0]       r_cause, w_cause;
   logic             w_retire, w_ack, w_expired, w_wbcls;
   logic             w_f, w_e, w_m, w_w, w_alu;
   logic             w_fn, w_st, w_ld, w_ralu, w_ialu, w_auipc, w_lui, w_jal, w_jalr, w_br;
   assign {w_fn, w_st, w_ld, w_ralu, w_ialu, w_auipc, w_lui, w_jal, w_jalr, w_br} = r_cls;
   assign w_wbcls   = w_ralu || w_ialu || w_lui || w_auipc || w_jal || w_jalr;
   assign w_ack     = (r_state == S_FETCH && bus.imem_ack) || (r_state == S_MEM && bus.dmem_ack);
   assign w_expired = r_tmo == TW'(TIMEOUT - 1);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_FETCH;
         r_cls     <= '0;
         r_tmo     <= '0;
         r_instret <= '0;
         r_cause   <= 2'd0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE) r_cls <= bus.op_class;
         r_tmo <= (w_next != r_state || w_ack || !(r_state == S_FETCH || r_state == S_MEM)) ? '0 : r_tmo + 1'b1;
         if (w_retire) r_instret <= r_instret + 1'b1;
         if (w_cause != 2'd0) r_cause <= w_cause;
      end
   end
   // an ack in the limit cycle is checked first, so it wins over the timeout
   always_comb begin
      w_next   = r_state;
      w_retire = 1'b0;
      w_cause  = 2'd0;
      case (r_state)
         S_FETCH: begin
            if (bus.imem_ack) w_next = S_DECODE;
            else if (w_expired) begin
               w_next  = S_TRAP;
               w_cause = 2'd2;
            end
         end
         S_DECODE: begin
            w_next  = $onehot(bus.op_class) ? S_EXEC : S_TRAP;
            w_cause = $onehot(bus.op_class) ? 2'd0 : 2'd1;
         end
         S_EXEC: begin
            w_next   = (w_ld || w_st) ? S_MEM : w_wbcls ? S_WB : S_FETCH;
            w_retire = !(w_ld || w_st || w_wbcls);
         end
         S_MEM: begin
            if (bus.dmem_ack) begin
               w_next   = w_st ? S_FETCH : S_WB;
               w_retire = w_st;
            end else if (w_expired) begin
               w_next  = S_TRAP;
               w_cause = 2'd3;
            end
         end
         S_WB: begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
         end
         default: w_next = r_state;
      endcase
   end
   assign w_f   = !rst && r_state == S_FETCH;
   assign w_e   = !rst && r_state == S_EXEC;
   assign w_m   = !rst && r_state == S_MEM;
   assign w_w   = !rst && r_state == S_WB;
   assign w_alu = w_e || w_m || w_w;
   always_comb begin
      bus.imem_req   = w_f;
      bus.ir_we      = w_f && bus.imem_ack;
      bus.dmem_req   = w_m;
      bus.dmem_we    = w_m && w_st;
      bus.pc_we      = (w_e && (w_br || w_fn)) || (w_m && bus.dmem_ack && w_st) || w_w;
      bus.pc_sel     = ((w_e && w_br && bus.branch_taken) || (w_w && w_jal)) ? 2'd1 :
                       (w_w && w_jalr) ? 2'd2 : 2'd0;
      bus.alu_a_sel  = w_alu && (w_auipc || w_jal);
      bus.alu_b_sel  = w_alu && (w_ialu || w_ld || w_st || w_jalr || w_auipc || w_jal);
      bus.rf_we      = w_w;
      bus.wb_sel     = !w_w ? 2'd0 : w_ld ? 2'd1 : (w_jal || w_jalr) ? 2'd2 : w_lui ? 2'd3 : 2'd0;
      bus.trap       = !rst && r_state == S_TRAP;
      bus.trap_cause = r_cause;
      bus.instret    = r_instret;
      bus.state      = r_state;
   end
endmodule

// File: tb/tb_rv32i_control_fsm.sv
// tb_rv32i_control_fsm: expands each instruction into its expected per-cycle trace
// from the class rules, then replays it against the sequencer.
module tb_rv32i_control_fsm;
   localparam int TMO = 16;
   localparam int CW  = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   rv32i_control_fsm_if #(.CNT_W(CW)) bus ();
   rv32i_control_fsm #(.TIMEOUT(TMO), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
   typedef struct packed {
      logic [2:0] st;
      logic       ireq, irwe, dreq, dwe, pcwe;
      logic [1:0] pcsel;
      logic       a, b, rfwe;
      logic [1:0] wbsel;
      logic       trap;
      logic [1:0] cause;
   } obs_t;
   typedef struct {
      logic          iack, dack, tk;
      logic [9:0]    oc;
      obs_t          e;
      logic [CW-1:0] ret;
      string         tag;
   } cyc_t;
   cyc_t          q[$];
   int            checks = 0;
   int            errors = 0;
   logic [CW-1:0] m_ret;
   bit            m_trap;
   function automatic obs_t base(input logic [2:0] st);
      obs_t r;
      r    = '0;
      r.st = st;
      return r;
   endfunction
   function automatic logic rb();
      return 1'($urandom);
   endfunction
   function automatic logic [9:0] roc();
      return 10'($urandom);
   endfunction
   task automatic push(input string tag, input logic iack, input logic dack, input logic [9:0] oc,
                       input logic tk, input obs_t e, input bit retire);
      cyc_t c;
      c.iack = iack; c.dack = dack; c.oc = oc; c.tk = tk; c.e = e; c.ret = m_ret; c.tag = tag;
      q.push_back(c);
      if (retire) m_ret = m_ret + 1'b1;
   endtask
   task automatic trap_tail(input string tag, input logic [1:0] cause);
      obs_t e;
      e       = base(3'd5);
      e.trap  = 1'b1;
      e.cause = cause;
      for (int i = 0; i < 3; i++) push(tag, rb(), rb(), roc(), rb(), e, 1'b0);
      m_trap = 1'b1;
   endtask
   // class bits: 0 branch,1 jalr,2 jal,3 lui,4 auipc,5 i_alu,6 r_alu,7 ld,8 store,9 fence
   task automatic plan(input string tag, input logic [9:0] oc, input int fw, input int mw, input logic tk);
      obs_t e;
      logic a, b;
      for (int i = 0; i < fw && i < TMO; i++) begin
         e = base(3'd0); e.ireq = 1'b1;
         push(tag, 1'b0, rb(), roc(), rb(), e, 1'b0);
      end
      if (fw >= TMO) begin
         trap_tail(tag, 2'd2);
         return;
      end
      e = base(3'd0); e.ireq = 1'b1; e.irwe = 1'b1;
      push(tag, 1'b1, rb(), roc(), rb(), e, 1'b0);
      push(tag, rb(), rb(), oc, rb(), base(3'd1), 1'b0);
      if (!$onehot(oc)) begin
         trap_tail(tag, 2'd1);
         return;
      end
      a = oc[4] | oc[2];
      b = oc[5] | oc[7] | oc[8] | oc[1] | oc[4] | oc[2];
      e = base(3'd2); e.a = a; e.b = b;
      e.pcwe  = oc[0] | oc[9];
      e.pcsel = {1'b0, oc[0] & tk};
      push(tag, rb(), rb(), roc(), tk, e, oc[0] | oc[9]);
      if (oc[0] | oc[9]) return;
      if (oc[7] | oc[8]) begin
         for (int i = 0; i < mw && i < TMO; i++) begin
            e = base(3'd3); e.dreq = 1'b1; e.dwe = oc[8]; e.a = a; e.b = b;
            push(tag, rb(), 1'b0, roc(), rb(), e, 1'b0);
         end
         if (mw >= TMO) begin
            trap_tail(tag, 2'd3);
            return;
         end
         e = base(3'd3); e.dreq = 1'b1; e.dwe = oc[8]; e.a = a; e.b = b; e.pcwe = oc[8];
         push(tag, rb(), 1'b1, roc(), rb(), e, oc[8]);
         if (oc[8]) return;
      end
      e = base(3'd4); e.rfwe = 1'b1; e.pcwe = 1'b1;
      e.wbsel = oc[7] ? 2'd1 : (oc[1] | oc[2]) ? 2'd2 : oc[3] ? 2'd3 : 2'd0;
      e.pcsel = oc[2] ? 2'd1 : oc[1] ? 2'd2 : 2'd0;
      push(tag, rb(), rb(), roc(), rb(), e, 1'b1);
   endtask
   function automatic obs_t sample();
      obs_t r;
      logic alu_vis;
      alu_vis = bus.state == 3'd2 || bus.state == 3'd3;
      r.st = bus.state; r.ireq = bus.imem_req; r.irwe = bus.ir_we; r.dreq = bus.dmem_req;
      r.dwe = bus.dmem_we; r.pcwe = bus.pc_we; r.pcsel = bus.pc_sel;
      r.a = alu_vis & bus.alu_a_sel; r.b = alu_vis & bus.alu_b_sel;
      r.rfwe = bus.rf_we; r.wbsel = bus.wb_sel; r.trap = bus.trap; r.cause = bus.trap_cause;
      return r;
   endfunction
   task automatic check(input string tag, input obs_t exp_o, input logic [CW-1:0] exp_r);
      obs_t got;
      got = sample();
      checks++;
      assert (got === exp_o) else begin
         errors++;
         $error("FAIL %s outputs observed=%h expected=%h", tag, got, exp_o);
      end
      checks++;
      assert (bus.instret === exp_r) else begin
         errors++;
         $error("FAIL %s instret observed=%0d expected=%0d", tag, bus.instret, exp_r);
      end
   endtask
   task automatic play(input int n);
      cyc_t c;
      int k = 0;
      while (q.size() > 0 && (n < 0 || k < n)) begin
         c = q.pop_front();
         k++;
         bus.imem_ack = c.iack; bus.dmem_ack = c.dack; bus.op_class = c.oc; bus.branch_taken = c.tk;
         #1;
         check(c.tag, c.e, c.ret);
         @(negedge clk);
      end
   endtask
   task automatic do_reset();
      rst = 1'b1;
      bus.imem_ack = 1'b1; bus.dmem_ack = 1'b1; bus.op_class = roc(); bus.branch_taken = 1'b1;
      #1;
      check("reset", base(3'd0), '0);
      @(negedge clk);
      rst = 1'b0;
      q.delete();
      m_ret  = '0;
      m_trap = 1'b0;
   endtask
   initial begin
      int r, fw, mw;
      logic [9:0] oc;
      m_ret = '0; m_trap = 1'b0;
      bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0; bus.op_class = '0; bus.branch_taken = 1'b0;
      @(negedge clk);
      do_reset();
      plan("rtype", 10'h040, 0, 0, 1'b0); play(-1);
      plan("load", 10'h080, 0, 3, 1'b0); play(-1);
      plan("br_taken", 10'h001, 0, 0, 1'b1); plan("br_not", 10'h001, 0, 0, 1'b0); play(-1);
      plan("fence", 10'h200, 2, 0, 1'b0); plan("store", 10'h100, 1, 2, 1'b0);
      plan("jal", 10'h004, 0, 0, 1'b0); plan("jalr", 10'h002, 1, 0, 1'b0);
      plan("lui", 10'h008, 0, 0, 1'b0); plan("auipc", 10'h010, 0, 0, 1'b0);
      plan("ialu", 10'h020, 0, 0, 1'b0); play(-1);
      plan("fetch_ack_limit", 10'h040, TMO - 1, 0, 1'b0); play(-1);
      plan("data_ack_limit", 10'h100, 0, TMO - 1, 1'b0); play(-1);
      plan("illegal_zero", 10'h000, 0, 0, 1'b0); play(-1); do_reset();
      plan("illegal_two", 10'h041, 0, 0, 1'b0); play(-1); do_reset();
      plan("fetch_tmo", 10'h040, TMO, 0, 1'b0); play(-1); do_reset();
      plan("data_tmo", 10'h080, 0, TMO, 1'b0); play(-1); do_reset();
      for (int i = 0; i < 17; i++) plan("wrap", 10'h040, 0, 0, 1'b0);
      play(-1);
      plan("pre_rst", 10'h020, 0, 0, 1'b0); plan("rst_mem", 10'h080, 0, 6, 1'b0); play(9);
      #2 rst = 1'b1;
      bus.dmem_ack = 1'b0;
      #1;
      check("async_rst", base(3'd0), '0);
      @(negedge clk);
      bus.dmem_ack = 1'b1;
      @(negedge clk);
      rst = 1'b0; q.delete(); m_ret = '0; m_trap = 1'b0;
      plan("post_rst", 10'h040, 0, 0, 1'b0); play(-1);
      for (int i = 0; i < 150; i++) begin
         r  = $urandom_range(0, 99);
         oc = r < 4 ? roc() : r < 6 ? 10'h000 : 10'(1 << $urandom_range(0, 9));
         fw = r >= 98 ? TMO : $urandom_range(0, 2);
         mw = r == 97 ? TMO : $urandom_range(0, 3);
         plan("random", oc, fw, mw, rb());
         play(-1);
         if (m_trap) do_reset();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
